pipe_hazard_ctrl: RTL

- Sequential successor to the single-cycle control decoder. It carries decoded control bundles through the EX, MEM and WB pipeline registers.
- Detects RAW and load-use hazards, generates IF/ID stall and flush, and produces forwarding selects for the EX-stage ALU operands.
- Sits between the ID-stage decoder and the datapath pipeline registers of the 5-stage RISC-V core.
- Width, forwarding mode and counter width are parametrised.

---
 rtl/pipe_hazard_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control carrier: holds the EX/MEM/WB control registers, detects RAW and
// load-use hazards, drives IF/ID stall/flush and the EX operand forwarding selects.
module pipe_hazard_ctrl #(
   parameter int REG_AW = 5,
   parameter int CTRL_W = 24,
   parameter bit FWD_EN = 1'b1,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              freeze,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_regwrite,
   input  logic              id_memread,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic              ex_redirect,
   output logic              ex_valid,
   output logic              mem_valid,
   output logic              wb_valid,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic [CTRL_W-1:0] mem_ctrl,
   output logic [CTRL_W-1:0] wb_ctrl,
   output logic              ex_regwrite,
   output logic              mem_regwrite,
   output logic              wb_regwrite,
   output logic [REG_AW-1:0] ex_rd,
   output logic [REG_AW-1:0] mem_rd,
   output logic [REG_AW-1:0] wb_rd,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic              stall,
   output logic              flush,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   typedef struct packed {
      logic              valid;
      logic [CTRL_W-1:0] ctrl;
      logic              regwrite;
      logic              memread;
      logic [REG_AW-1:0] rd;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
      logic              use_rs1;
      logic              use_rs2;
   } ex_stage_t;

   typedef struct packed {
      logic              valid;
      logic [CTRL_W-1:0] ctrl;
      logic              regwrite;
      logic [REG_AW-1:0] rd;
   } late_stage_t;

   ex_stage_t   ex_q, ex_d;
   late_stage_t mem_q, mem_d;
   late_stage_t wb_q, wb_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic id_ex_hit;
   logic id_mem_hit;
   logic load_use;
   logic raw_stall;
   logic bubble;
   logic mem_hit_a, mem_hit_b;
   logic wb_hit_a, wb_hit_b;

   // A producer only counts if it is live, writes, targets a non-x0 register and the
   // consumer really reads that operand.
   function automatic logic rd_hit(input logic              v,
                                   input logic              rw,
                                   input logic [REG_AW-1:0] rd,
                                   input logic [REG_AW-1:0] rs,
                                   input logic              use_rs);
      return v & rw & (rd != '0) & (rd == rs) & use_rs;
   endfunction

   // stall is the hold request to the upstream IF/ID register: while it is high the
   // same ID contents are presented again on the following cycle.
   always_comb begin
      id_ex_hit  = rd_hit(ex_q.valid, ex_q.regwrite, ex_q.rd, id_rs1, id_use_rs1)
                 | rd_hit(ex_q.valid, ex_q.regwrite, ex_q.rd, id_rs2, id_use_rs2);
      id_mem_hit = rd_hit(mem_q.valid, mem_q.regwrite, mem_q.rd, id_rs1, id_use_rs1)
                 | rd_hit(mem_q.valid, mem_q.regwrite, mem_q.rd, id_rs2, id_use_rs2);
      load_use   = id_ex_hit & ex_q.memread;
      raw_stall  = id_valid & (FWD_EN ? load_use : (id_ex_hit | id_mem_hit));
      stall      = raw_stall & ~ex_redirect;
      flush      = ex_redirect;
      bubble     = raw_stall | ex_redirect;
   end

   always_comb begin
      mem_hit_a = rd_hit(mem_q.valid, mem_q.regwrite, mem_q.rd, ex_q.rs1, ex_q.use_rs1);
      mem_hit_b = rd_hit(mem_q.valid, mem_q.regwrite, mem_q.rd, ex_q.rs2, ex_q.use_rs2);
      wb_hit_a  = rd_hit(wb_q.valid, wb_q.regwrite, wb_q.rd, ex_q.rs1, ex_q.use_rs1);
      wb_hit_b  = rd_hit(wb_q.valid, wb_q.regwrite, wb_q.rd, ex_q.rs2, ex_q.use_rs2);
      fwd_a = 2'b00;
      fwd_b = 2'b00;
      if (FWD_EN) begin
         // The younger result in MEM shadows the older one in WB.
         if (mem_hit_a)     fwd_a = 2'b10;
         else if (wb_hit_a) fwd_a = 2'b01;
         if (mem_hit_b)     fwd_b = 2'b10;
         else if (wb_hit_b) fwd_b = 2'b01;
      end
   end

   always_comb begin
      ex_d = '0;
      if (!bubble) begin
         ex_d.valid    = id_valid;
         ex_d.ctrl     = id_valid ? id_ctrl : '0;
         ex_d.regwrite = id_valid & id_regwrite;
         ex_d.memread  = id_valid & id_memread;
         ex_d.rd       = id_rd;
         ex_d.rs1      = id_rs1;
         ex_d.rs2      = id_rs2;
         ex_d.use_rs1  = id_use_rs1;
         ex_d.use_rs2  = id_use_rs2;
      end
      mem_d.valid    = ex_q.valid;
      mem_d.ctrl     = ex_q.ctrl;
      mem_d.regwrite = ex_q.regwrite;
      mem_d.rd       = ex_q.rd;
      wb_d           = mem_q;
      stall_cnt_d    = stall_cnt_q + {{(CNT_W-1){1'b0}}, stall};
      flush_cnt_d    = flush_cnt_q + {{(CNT_W-1){1'b0}}, flush};
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ex_q        <= '0;
         mem_q       <= '0;
         wb_q        <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else if (!freeze) begin
         ex_q        <= ex_d;
         mem_q       <= mem_d;
         wb_q        <= wb_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign ex_valid     = ex_q.valid;
   assign mem_valid    = mem_q.valid;
   assign wb_valid     = wb_q.valid;
   assign ex_ctrl      = ex_q.ctrl;
   assign mem_ctrl     = mem_q.ctrl;
   assign wb_ctrl      = wb_q.ctrl;
   assign ex_regwrite  = ex_q.regwrite;
   assign mem_regwrite = mem_q.regwrite;
   assign wb_regwrite  = wb_q.regwrite;
   assign ex_rd        = ex_q.rd;
   assign mem_rd       = mem_q.rd;
   assign wb_rd        = wb_q.rd;
   assign stall_cnt    = stall_cnt_q;
   assign flush_cnt    = flush_cnt_q;

endmodule
